// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: credit-limited requests to instruction memory, a two-entry
// response FIFO and the IF/ID pipeline register, with stall and redirect handling.
module if_fetch_unit #(
    parameter int unsigned      BUS_W    = 32,
    parameter logic [BUS_W-1:0] RESET_PC = BUS_W'(32'h0000_0000),
    parameter logic [BUS_W-1:0] NOP_INST = BUS_W'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallIn,
    input  logic             redirectIn,
    input  logic [BUS_W-1:0] redirectPcIn,
    output logic             imemReqOut,
    output logic [BUS_W-1:0] imemAddrOut,
    input  logic             imemGntIn,
    input  logic             imemRvalidIn,
    input  logic [BUS_W-1:0] imemRdataIn,
    output logic [BUS_W-1:0] instOut_IFID,
    output logic [BUS_W-1:0] pcOut_IFID,
    output logic             validOut_IFID,
    output logic             protoErrOut
);

    logic [BUS_W-1:0]            pc_q, pc_d;
    logic [1:0]                  live_cnt_q, live_cnt_d;
    logic [1:0]                  drop_cnt_q, drop_cnt_d;
    logic [1:0]                  buf_cnt_q, buf_cnt_d;
    logic [1:0][BUS_W-1:0]       fifo_inst_q, fifo_inst_d;
    logic [1:0][BUS_W-1:0]       fifo_pc_q, fifo_pc_d;
    logic                        fifo_rd_q, fifo_rd_d;
    logic                        fifo_wr_q, fifo_wr_d;
    logic [1:0][BUS_W-1:0]       pcq_q, pcq_d;
    logic                        pcq_rd_q, pcq_rd_d;
    logic                        pcq_wr_q, pcq_wr_d;
    logic [BUS_W-1:0]            if_inst_q, if_inst_d;
    logic [BUS_W-1:0]            if_pc_q, if_pc_d;
    logic                        if_valid_q, if_valid_d;
    logic                        proto_err_q, proto_err_d;

    logic [2:0] in_flight;
    logic [2:0] credits_used;
    logic       req;
    logic       accept;
    logic       resp_any;
    logic       resp_drop;
    logic       resp_live;
    logic       pop;

    // Every request, in flight or buffered, holds one of two credits, so the FIFO never overflows.
    assign in_flight    = {1'b0, live_cnt_q} + {1'b0, drop_cnt_q};
    assign credits_used = in_flight + {1'b0, buf_cnt_q};
    assign req          = rst & ~redirectIn & (credits_used < 3'd2);
    assign accept       = req & imemGntIn;
    assign resp_any     = imemRvalidIn & (in_flight != 3'd0);
    assign resp_drop    = resp_any & (drop_cnt_q != 2'd0);
    assign resp_live    = resp_any & (drop_cnt_q == 2'd0);
    assign pop          = ~redirectIn & ~stallIn & (buf_cnt_q != 2'd0);

    always_comb begin
        pc_d        = pc_q;
        live_cnt_d  = live_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        buf_cnt_d   = buf_cnt_q;
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_wr_d   = fifo_wr_q;
        pcq_d       = pcq_q;
        pcq_rd_d    = pcq_rd_q;
        pcq_wr_d    = pcq_wr_q;
        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        if_valid_d  = if_valid_q;
        proto_err_d = proto_err_q;

        if (accept) begin
            pc_d           = pc_q + BUS_W'(4);
            pcq_d[pcq_wr_q] = pc_q;
            pcq_wr_d       = ~pcq_wr_q;
        end

        if (imemRvalidIn && (in_flight == 3'd0)) begin
            proto_err_d = 1'b1;
        end

        if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end

        // Live responses pair with the oldest queued request PC.
        if (resp_live) begin
            fifo_inst_d[fifo_wr_q] = imemRdataIn;
            fifo_pc_d[fifo_wr_q]   = pcq_q[pcq_rd_q];
            fifo_wr_d              = ~fifo_wr_q;
            pcq_rd_d               = ~pcq_rd_q;
        end

        live_cnt_d = live_cnt_q + {1'b0, accept} - {1'b0, resp_live};
        buf_cnt_d  = buf_cnt_q + {1'b0, resp_live} - {1'b0, pop};

        if (pop) begin
            if_inst_d  = fifo_inst_q[fifo_rd_q];
            if_pc_d    = fifo_pc_q[fifo_rd_q];
            if_valid_d = 1'b1;
            fifo_rd_d  = ~fifo_rd_q;
        end else if (!redirectIn && !stallIn) begin
            if_inst_d  = NOP_INST;
            if_pc_d    = '0;
            if_valid_d = 1'b0;
        end

        // Redirect wins over stall; requests still outstanding become responses to discard.
        if (redirectIn) begin
            pc_d       = redirectPcIn;
            live_cnt_d = 2'd0;
            drop_cnt_d = drop_cnt_q + live_cnt_q - {1'b0, resp_any};
            buf_cnt_d  = 2'd0;
            fifo_rd_d  = 1'b0;
            fifo_wr_d  = 1'b0;
            pcq_rd_d   = 1'b0;
            pcq_wr_d   = 1'b0;
            if_inst_d  = NOP_INST;
            if_pc_d    = '0;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            live_cnt_q  <= 2'd0;
            drop_cnt_q  <= 2'd0;
            buf_cnt_q   <= 2'd0;
            fifo_inst_q <= '0;
            fifo_pc_q   <= '0;
            fifo_rd_q   <= 1'b0;
            fifo_wr_q   <= 1'b0;
            pcq_q       <= '0;
            pcq_rd_q    <= 1'b0;
            pcq_wr_q    <= 1'b0;
            if_inst_q   <= NOP_INST;
            if_pc_q     <= '0;
            if_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            live_cnt_q  <= live_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            buf_cnt_q   <= buf_cnt_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_wr_q   <= fifo_wr_d;
            pcq_q       <= pcq_d;
            pcq_rd_q    <= pcq_rd_d;
            pcq_wr_q    <= pcq_wr_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            if_valid_q  <= if_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign imemReqOut    = req;
    assign imemAddrOut   = pc_q;
    assign instOut_IFID  = if_inst_q;
    assign pcOut_IFID    = if_pc_q;
    assign validOut_IFID = if_valid_q;
    assign protoErrOut   = proto_err_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle table with hand-derived expectations, an in-order memory
// model and a scoreboard of instructions expected to reach IF/ID.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stallIn;
    logic        redirectIn;
    logic [31:0] redirectPcIn;
    logic        imemReqOut;
    logic [31:0] imemAddrOut;
    logic        imemGntIn;
    logic        imemRvalidIn;
    logic [31:0] imemRdataIn;
    logic [31:0] instOut_IFID;
    logic [31:0] pcOut_IFID;
    logic        validOut_IFID;
    logic        protoErrOut;

    if_fetch_unit #(
        .BUS_W   (32),
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallIn      (stallIn),
        .redirectIn   (redirectIn),
        .redirectPcIn (redirectPcIn),
        .imemReqOut   (imemReqOut),
        .imemAddrOut  (imemAddrOut),
        .imemGntIn    (imemGntIn),
        .imemRvalidIn (imemRvalidIn),
        .imemRdataIn  (imemRdataIn),
        .instOut_IFID (instOut_IFID),
        .pcOut_IFID   (pcOut_IFID),
        .validOut_IFID(validOut_IFID),
        .protoErrOut  (protoErrOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        gnt;
        logic        hold;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    vec_t vecs[$];
    req_t respQ[$];
    exp_t expQ[$];

    int          checks = 0;
    int          errors = 0;
    int          epoch  = 0;
    logic [31:0] modelPc;
    logic        obsReq;
    logic [31:0] obsAddr;
    logic        obsValid;
    logic [31:0] obsPc;
    logic [31:0] obsInst;
    logic        obsErr;

    function automatic logic [31:0] dataOf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mkVec(input logic stall, input logic redir, input logic [31:0] target,
                                   input logic gnt, input logic hold, input logic expReq,
                                   input logic [31:0] expAddr, input logic expValid,
                                   input logic [31:0] expPc);
        vec_t v;
        v.stall = stall; v.redir = redir; v.target = target; v.gnt = gnt; v.hold = hold;
        v.expReq = expReq; v.expAddr = expAddr; v.expValid = expValid; v.expPc = expPc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts just after a falling edge, drives one cycle, returns after the next falling edge.
    task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] target,
                                 input logic gnt, input logic hold);
        req_t r;
        exp_t e;
        stallIn      = stall;
        redirectIn   = redir;
        redirectPcIn = target;
        imemGntIn    = gnt;
        if (!hold && respQ.size() > 0) begin
            r = respQ.pop_front();
            imemRvalidIn = 1'b1;
            imemRdataIn  = dataOf(r.addr);
            if (r.epoch == epoch) expQ.push_back('{dataOf(r.addr), r.pc});
        end else begin
            imemRvalidIn = 1'b0;
            imemRdataIn  = '0;
        end
        if (redir) begin
            epoch++;
            expQ.delete();
        end
        #1;
        obsReq  = imemReqOut;
        obsAddr = imemAddrOut;
        if (imemReqOut && gnt) begin
            checkOutput("fetch_addr", imemAddrOut, modelPc);
            respQ.push_back('{imemAddrOut, modelPc, epoch});
            modelPc = modelPc + 32'd4;
        end
        if (redir) modelPc = target;
        @(posedge clk);
        #1;
        obsValid = validOut_IFID;
        obsPc    = pcOut_IFID;
        obsInst  = instOut_IFID;
        obsErr   = protoErrOut;
        if (!stall && !redir && obsValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_underflow: got pc %h, expected no valid instruction", obsPc);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_inst", obsInst, e.inst);
                checkOutput("sb_pc", obsPc, e.pc);
            end
        end
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"}, 32'(imemReqOut), 32'd0);
        checkOutput({tag, "_addr"}, imemAddrOut, RESET_PC);
        checkOutput({tag, "_valid"}, 32'(validOut_IFID), 32'd0);
        checkOutput({tag, "_inst"}, instOut_IFID, NOP_INST);
        checkOutput({tag, "_pc"}, pcOut_IFID, 32'd0);
    endtask

    initial begin
        rst = 1'b0; stallIn = 1'b0; redirectIn = 1'b0; redirectPcIn = '0;
        imemGntIn = 1'b0; imemRvalidIn = 1'b0; imemRdataIn = '0;
        modelPc = RESET_PC;

        //                 stall redir target     gnt hold req  addr       valid pc
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h000, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h004, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 0, 32'h000, 1, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h008, 1, 32'h004));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h00C, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 0, 32'h000, 1, 32'h008));
        vecs.push_back(mkVec(1, 0, 32'h0,   1, 0, 1, 32'h010, 1, 32'h008));
        vecs.push_back(mkVec(1, 0, 32'h0,   1, 0, 0, 32'h000, 1, 32'h008));
        vecs.push_back(mkVec(1, 0, 32'h0,   1, 0, 0, 32'h000, 1, 32'h008));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 0, 32'h000, 1, 32'h00C));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h014, 1, 32'h010));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h018, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 1, 0, 32'h000, 1, 32'h014));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 1, 1, 32'h01C, 0, 32'h000));
        vecs.push_back(mkVec(0, 1, 32'h100, 1, 1, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h100, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h104, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 0, 32'h000, 1, 32'h100));
        vecs.push_back(mkVec(1, 1, 32'h200, 1, 0, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h200, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   0, 0, 1, 32'h204, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   0, 0, 1, 32'h204, 1, 32'h200));
        vecs.push_back(mkVec(0, 0, 32'h0,   0, 0, 1, 32'h204, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   0, 0, 1, 32'h204, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   0, 0, 1, 32'h204, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h204, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h208, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 0, 32'h000, 1, 32'h204));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h20C, 1, 32'h208));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h210, 0, 32'h000));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 0, 32'h000, 1, 32'h20C));
        vecs.push_back(mkVec(0, 0, 32'h0,   1, 0, 1, 32'h214, 1, 32'h210));

        repeat (3) @(negedge clk);
        checkResetState("rst0");
        checkOutput("rst0_err", 32'(protoErrOut), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stall, vecs[i].redir, vecs[i].target, vecs[i].gnt, vecs[i].hold);
            checkOutput($sformatf("r%0d_req", i + 1), 32'(obsReq), 32'(vecs[i].expReq));
            if (vecs[i].expReq) checkOutput($sformatf("r%0d_addr", i + 1), obsAddr, vecs[i].expAddr);
            checkOutput($sformatf("r%0d_valid", i + 1), 32'(obsValid), 32'(vecs[i].expValid));
            checkOutput($sformatf("r%0d_pc", i + 1), obsPc, vecs[i].expValid ? vecs[i].expPc : 32'd0);
            checkOutput($sformatf("r%0d_inst", i + 1), obsInst,
                        vecs[i].expValid ? dataOf(vecs[i].expPc) : NOP_INST);
        end
        checkOutput("table_err", 32'(protoErrOut), 32'd0);

        // Reset with a request in flight; its late response must be flagged, not buffered.
        rst = 1'b0; stallIn = 1'b0; redirectIn = 1'b0; imemGntIn = 1'b0; imemRvalidIn = 1'b0;
        #1;
        checkResetState("rst1");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        epoch++;
        expQ.delete();
        modelPc = RESET_PC;

        applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("first_req", 32'(obsReq), 32'd1);
        checkOutput("first_addr", obsAddr, RESET_PC);
        checkOutput("spur_err", 32'(obsErr), 32'd1);
        checkOutput("spur_valid", 32'(obsValid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 32'h0, 0, 0);
            checkOutput($sformatf("sticky_err%0d", i), 32'(obsErr), 32'd1);
            checkOutput($sformatf("spur_valid%0d", i), 32'(obsValid), 32'd0);
            checkOutput($sformatf("spur_inst%0d", i), obsInst, NOP_INST);
            checkOutput($sformatf("stable_addr%0d", i), obsAddr, RESET_PC);
        end

        applyStimulus(0, 0, 32'h0, 1, 0);
        applyStimulus(0, 0, 32'h0, 1, 0);
        applyStimulus(0, 0, 32'h0, 1, 0);
        checkOutput("resume_valid", 32'(obsValid), 32'd1);
        checkOutput("resume_pc", obsPc, RESET_PC);
        checkOutput("resume_err", 32'(obsErr), 32'd1);

        repeat (4) applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("mem_drained", 32'(respQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
